// File: rtl/buffer_pkg.sv
// Shared types and constants for the double-buffered audio RAM path
// (playback scheduler, FAT32 writer and the RAM address split).
package buffer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SWAP,
      ST_WAIT_TICK,
      ST_FETCH,
      ST_EMIT,
      ST_UNDERRUN
   } state_t;

   localparam int SAMPLE_BYTES             = 4;
   localparam int SAMPLE_BITS              = 16;
   localparam int BYTE_IDX_BITS            = $clog2(SAMPLE_BYTES);
   localparam int DEFAULT_BUFFER_ADDR_BITS = 9;

endpackage

// File: rtl/sample_assembler.sv
// Byte shift-in register: collects L[7:0], L[15:8], R[7:0] and publishes the
// stereo words together with the final byte R[15:8]; mute forces silence.
module sample_assembler
   import buffer_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cap_en_i,
   input  logic [BYTE_IDX_BITS-1:0] byte_idx_i,
   input  logic [7:0]               byte_i,
   input  logic                     mute_i,
   output logic [SAMPLE_BITS-1:0]   left_o,
   output logic [SAMPLE_BITS-1:0]   right_o
);

   logic [8*(SAMPLE_BYTES-1)-1:0] r_bytes;
   logic                          w_last;

   assign w_last = cap_en_i && (byte_idx_i == BYTE_IDX_BITS'(SAMPLE_BYTES-1));

   always_ff @(posedge clk) begin
      if (cap_en_i) begin
         case (byte_idx_i)
            2'd0:    r_bytes[7:0]   <= byte_i;
            2'd1:    r_bytes[15:8]  <= byte_i;
            2'd2:    r_bytes[23:16] <= byte_i;
            default: r_bytes        <= r_bytes;
         endcase
      end
   end

   // Outputs only change on a completed sample or a mute, so they hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_o  <= '0;
         right_o <= '0;
      end else if (mute_i) begin
         left_o  <= '0;
         right_o <= '0;
      end else if (w_last) begin
         left_o  <= r_bytes[15:0];
         right_o <= {byte_i, r_bytes[23:16]};
      end
   end

endmodule

// File: rtl/audio_playback_scheduler.sv
// Read-side controller for the double-buffered audio RAM: owns half select and
// read address, fetches one stereo sample per tick. Option: UNDERRUN_MUTE_EN.
module audio_playback_scheduler
   import buffer_pkg::*;
#(
   parameter int BUFFER_ADDR_BITS = DEFAULT_BUFFER_ADDR_BITS,
   parameter int RAM_RD_LATENCY   = 1
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        sample_tick_i,
   input  logic                        buffer_filled_i,
   input  logic [7:0]                  ram_rd_data_i,
   output logic                        buffer_active_sel_o,
   output logic [BUFFER_ADDR_BITS-1:0] buffer_rd_addr_o,
   output logic                        buffer_empty_o,
   output logic [SAMPLE_BITS-1:0]      sample_left_o,
   output logic [SAMPLE_BITS-1:0]      sample_right_o,
   output logic                        sample_valid_o,
   output logic                        playing_o,
   output logic                        underrun_o,
   output logic                        tick_missed_o
);

   state_t                     r_state, w_state_nxt;
   logic                       r_filled_q, r_filled_q2;
   logic                       r_pending, r_empty, r_sel, r_valid, r_missed;
   logic [BUFFER_ADDR_BITS-1:0] r_addr;
   logic [BYTE_IDX_BITS-1:0]   r_byte_idx;
   logic [1:0]                 r_wait;
   logic                       w_edge, w_swap, w_capture, w_last, w_mute, w_busy;

   assign w_edge    = r_filled_q & ~r_filled_q2;
   assign w_swap    = (r_state == ST_SWAP);
   assign w_capture = (r_state == ST_FETCH) && (r_wait == 2'(RAM_RD_LATENCY));
   assign w_last    = w_capture && (r_byte_idx == BYTE_IDX_BITS'(SAMPLE_BYTES-1));
   assign w_busy    = (r_state == ST_FETCH) || (r_state == ST_EMIT) || w_swap;
`ifdef UNDERRUN_MUTE_EN
   assign w_mute    = (r_state == ST_UNDERRUN) && sample_tick_i;
`else
   assign w_mute    = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (r_pending) w_state_nxt = ST_SWAP;
         ST_SWAP:      w_state_nxt = ST_WAIT_TICK;
         ST_WAIT_TICK: if (sample_tick_i) w_state_nxt = ST_FETCH;
         ST_FETCH:     if (w_last) w_state_nxt = ST_EMIT;
         ST_EMIT: begin
            if (r_addr == '0) w_state_nxt = r_pending ? ST_SWAP : ST_UNDERRUN;
            else              w_state_nxt = ST_WAIT_TICK;
         end
         ST_UNDERRUN:  if (r_pending) w_state_nxt = ST_SWAP;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_filled_q  <= 1'b0;
         r_filled_q2 <= 1'b0;
         r_pending   <= 1'b0;
         r_empty     <= 1'b1;
         r_sel       <= 1'b0;
         r_addr      <= '0;
         r_byte_idx  <= '0;
         r_wait      <= '0;
         r_valid     <= 1'b0;
         r_missed    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_filled_q  <= buffer_filled_i;
         r_filled_q2 <= r_filled_q;
         // A fill edge in the swap cycle refers to the freshly released half, so it wins.
         r_pending   <= w_edge ? 1'b1 : (w_swap ? 1'b0 : r_pending);
         r_empty     <= ~r_pending;
         r_sel       <= r_sel ^ w_swap;
         if (w_swap)         r_addr <= '0;
         else if (w_capture) r_addr <= r_addr + BUFFER_ADDR_BITS'(1);
         if (r_state == ST_WAIT_TICK) r_byte_idx <= '0;
         else if (w_capture)          r_byte_idx <= r_byte_idx + BYTE_IDX_BITS'(1);
         if (w_capture || r_state != ST_FETCH) r_wait <= '0;
         else                                  r_wait <= r_wait + 2'd1;
         r_valid     <= w_last | w_mute;
         r_missed    <= r_missed | (sample_tick_i & w_busy);
      end
   end

   sample_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .cap_en_i   (w_capture),
      .byte_idx_i (r_byte_idx),
      .byte_i     (ram_rd_data_i),
      .mute_i     (w_mute),
      .left_o     (sample_left_o),
      .right_o    (sample_right_o)
   );

   assign buffer_active_sel_o = r_sel;
   assign buffer_rd_addr_o    = r_addr;
   assign buffer_empty_o      = r_empty;
   assign sample_valid_o      = r_valid;
   assign playing_o           = (r_state != ST_IDLE);
   assign underrun_o          = (r_state == ST_UNDERRUN);
   assign tick_missed_o       = r_missed;

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Bench for audio_playback_scheduler: directed scenarios plus random ticks and
// fills, checked every cycle against a transaction-level model.
module tb_audio_playback_scheduler;

   localparam int AB   = 4;
   localparam int LAT  = 1;
   localparam int HALF = 1 << AB;

   localparam int M_IDLE = 0, M_SWAP = 1, M_WAIT = 2, M_FETCH = 3, M_EMIT = 4, M_UNDER = 5;

   logic          clk = 1'b0;
   logic          rst_n, tick, filled;
   logic [7:0]    ram_data;
   logic          sel_o, empty_o, valid_o, playing_o, underrun_o, missed_o;
   logic [AB-1:0] addr_o;
   logic [15:0]   left_o, right_o;

   int checks = 0;
   int errors = 0;
   int vcnt;
   bit rand_done = 0;

   logic [7:0] mem [0:1][0:HALF-1];
   logic [7:0] rd_pipe [0:LAT-1];

   always #5 clk = ~clk;

   audio_playback_scheduler #(.BUFFER_ADDR_BITS(AB), .RAM_RD_LATENCY(LAT)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .sample_tick_i       (tick),
      .buffer_filled_i     (filled),
      .ram_rd_data_i       (ram_data),
      .buffer_active_sel_o (sel_o),
      .buffer_rd_addr_o    (addr_o),
      .buffer_empty_o      (empty_o),
      .sample_left_o       (left_o),
      .sample_right_o      (right_o),
      .sample_valid_o      (valid_o),
      .playing_o           (playing_o),
      .underrun_o          (underrun_o),
      .tick_missed_o       (missed_o)
   );

   // Dual-port RAM read side with LAT cycles of latency
   always @(posedge clk) begin
      rd_pipe[0] <= mem[sel_o][addr_o];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_data = rd_pipe[LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: whole samples are read from the half when the fetch time expires
   int          m_mode, m_cnt, m_addr;
   bit          m_f1, m_f2, m_pend, m_empty, m_sel, m_valid, m_missed;
   logic [15:0] m_left, m_right;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_IDLE; m_cnt = 0; m_addr = 0;
         m_f1 = 0; m_f2 = 0; m_pend = 0; m_empty = 1; m_sel = 0;
         m_valid = 0; m_missed = 0; m_left = 0; m_right = 0;
      end else begin
         automatic bit fedge = m_f1 && !m_f2;
         automatic bit old_pend = m_pend;
         automatic bit swapping = (m_mode == M_SWAP);
         m_f2 = m_f1;
         m_f1 = filled;
         m_empty = !old_pend;
         m_valid = 0;
         case (m_mode)
            M_IDLE: if (old_pend) m_mode = M_SWAP;
            M_SWAP: begin
               m_sel = !m_sel; m_addr = 0; m_mode = M_WAIT;
               if (tick) m_missed = 1;
            end
            M_WAIT: if (tick) begin m_mode = M_FETCH; m_cnt = 4 * (1 + LAT); end
            M_FETCH: begin
               if (tick) m_missed = 1;
               m_cnt--;
               if (m_cnt == 0) begin
                  m_left  = {mem[m_sel][m_addr+1], mem[m_sel][m_addr]};
                  m_right = {mem[m_sel][m_addr+3], mem[m_sel][m_addr+2]};
                  m_addr  = (m_addr + 4) % HALF;
                  m_valid = 1;
                  m_mode  = M_EMIT;
               end
            end
            M_EMIT: begin
               if (tick) m_missed = 1;
               if (m_addr == 0) m_mode = old_pend ? M_SWAP : M_UNDER;
               else             m_mode = M_WAIT;
            end
            default: begin
`ifdef UNDERRUN_MUTE_EN
               if (tick) begin m_valid = 1; m_left = 0; m_right = 0; end
`endif
               if (old_pend) m_mode = M_SWAP;
            end
         endcase
         m_pend = fedge ? 1'b1 : (swapping ? 1'b0 : old_pend);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_valid", valid_o, m_valid);
         chk("cyc_left", left_o, m_left);
         chk("cyc_right", right_o, m_right);
         chk("cyc_sel", sel_o, m_sel);
         chk("cyc_empty", empty_o, m_empty);
         chk("cyc_playing", playing_o, m_mode != M_IDLE);
         chk("cyc_underrun", underrun_o, m_mode == M_UNDER);
         chk("cyc_missed", missed_o, m_missed);
         if (m_mode != M_FETCH) chk("cyc_addr", addr_o, m_addr);
      end
   end

   task automatic fill();
      for (int i = 0; i < 200 && empty_o !== 1'b1; i++) @(negedge clk);
      chk("fill_wait_empty", empty_o, 1);
      for (int a = 0; a < HALF; a++) mem[!sel_o][a] = 8'($urandom);
      filled = 1'b1;
      repeat (2) @(negedge clk);
      filled = 1'b0;
      for (int i = 0; i < 50 && empty_o !== 1'b0; i++) @(negedge clk);
      chk("fill_ack", empty_o, 0);
   endtask

   task automatic tick_gap(input int gap);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; tick = 1'b0; filled = 1'b0;
      for (int h = 0; h < 2; h++)
         for (int a = 0; a < HALF; a++) mem[h][a] = 8'($urandom);
      mem[1][0] = 8'h34; mem[1][1] = 8'h12; mem[1][2] = 8'h78; mem[1][3] = 8'h56;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_sel", sel_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_left", left_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_playing", playing_o, 0);
      chk("rst_underrun", underrun_o, 0);
      chk("rst_missed", missed_o, 0);

      // First fill: swap to half 1, empty low through swap then high again
      repeat (8) @(negedge clk);
      filled = 1'b1;
      repeat (2) @(negedge clk);
      filled = 1'b0;
      for (int i = 0; i < 20 && sel_o !== 1'b1; i++) @(negedge clk);
      chk("swap_sel", sel_o, 1);
      chk("swap_addr", addr_o, 0);
      chk("swap_empty_low", empty_o, 0);
      @(negedge clk);
      chk("swap_empty_high", empty_o, 1);
      chk("swap_playing", playing_o, 1);

      // One sample: 9 cycles tick-to-strobe
      tick = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         tick = 1'b0;
         vcnt++;
         if (valid_o === 1'b1) break;
      end
      chk("tick_latency", vcnt, 9);
      chk("first_left", left_o, 16'h1234);
      chk("first_right", right_o, 16'h5678);
      chk("first_addr", addr_o, 4);

      // Two ticks 3 cycles apart: one sample, sticky miss
      tick_gap(3);
      vcnt = 0;
      tick = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tick = 1'b0;
         if (valid_o === 1'b1) vcnt++;
      end
      chk("miss_one_sample", vcnt, 1);
      chk("miss_sticky", missed_o, 1);

      // Pending fill: wrap swaps to half 0 with no underrun
      fill();
      tick_gap(15);
      tick_gap(15);
      chk("wrap_sel", sel_o, 0);
      chk("wrap_addr", addr_o, 0);
      chk("wrap_no_underrun", underrun_o, 0);

      // No fill: underrun after the 4th sample, recovery on a late fill
      repeat (4) tick_gap(15);
      chk("under_flag", underrun_o, 1);
      chk("under_addr", addr_o, 0);
      repeat (50) @(negedge clk);
      fill();
      for (int i = 0; i < 20 && underrun_o !== 1'b0; i++) @(negedge clk);
      chk("resume_underrun", underrun_o, 0);
      @(negedge clk);
      chk("resume_sel", sel_o, 1);
      chk("resume_addr", addr_o, 0);
      chk("still_missed", missed_o, 1);

      // Reset during fetch of byte 2
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_sel", sel_o, 0);
      chk("arst_addr", addr_o, 0);
      chk("arst_empty", empty_o, 1);
      chk("arst_left", left_o, 0);
      chk("arst_right", right_o, 0);
      chk("arst_valid", valid_o, 0);
      chk("arst_playing", playing_o, 0);
      chk("arst_missed", missed_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick = (i == 5);
         @(negedge clk);
         if (valid_o === 1'b1) vcnt++;
      end
      tick = 1'b0;
      chk("arst_no_sample", vcnt, 0);
      chk("arst_idle", playing_o, 0);
      chk("arst_idle_tick_silent", missed_o, 0);

      // Random ticks and writer fills
      fork
         begin
            repeat (3000) begin
               @(negedge clk);
               tick = ($urandom_range(0, 10) == 0);
            end
            tick = 1'b0;
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               repeat ($urandom_range(5, 150)) @(negedge clk);
               if (!rand_done && empty_o === 1'b1) fill();
            end
         end
      join
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_playback_scheduler.md
Name: audio_playback_scheduler

Overview:
Read-side controller for the double-buffered audio RAM.
- Owns the active-half select and the read address.
- Fetches one stereo 16-bit little-endian sample (4 bytes) from the active half per sample tick.
- Swaps halves when the active half is consumed and the writer has filled the other half.
- Drives the empty/filled handshake back to the FAT32 writer, between the dual-port RAM and the audio codec serializer.

Parameters:
BUFFER_ADDR_BITS, 9, byte address width of one buffer half (half size 2^N bytes; must be a multiple of 4)
RAM_RD_LATENCY, 1, cycles from rd address to valid ram_rd_data_i (1..3)

Ports:
clk  in  1  system clock (200 MHz domain)
rst_n  in  1  reset
sample_tick_i  in  1  single-cycle pulse at the sample rate
buffer_filled_i  in  1  writer status; a rising edge means the inactive half is completely written
ram_rd_data_i  in  8  RAM read-port data
buffer_active_sel_o  out  1  half currently being read; the writer uses !sel
buffer_rd_addr_o  out  BUFFER_ADDR_BITS  byte address within the active half
buffer_empty_o  out  1  high: inactive half is free for the writer
sample_left_o  out  16  left sample
sample_right_o  out  16  right sample
sample_valid_o  out  1  one-cycle strobe; samples are stable from the strobe until the next strobe
playing_o  out  1  high in any state other than IDLE
underrun_o  out  1  high while in UNDERRUN
tick_missed_o  out  1  sticky: a tick arrived while a fetch was still in progress

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset values:
- sel=0, addr=0, buffer_empty_o=1, samples=0.
- sample_valid_o, playing_o, underrun_o, tick_missed_o = 0.
- pending=0, state=IDLE.
- Reset asserted mid-fetch aborts immediately. No partial sample is emitted after release.

Handshake and pending flag:
- filled_i is registered once; an edge is detected on the registered value.
- A rising edge sets pending.
- buffer_empty_o = !pending, registered, so it falls 1 cycle after the registered edge.
- A rising edge while pending=1 is ignored.
- Writer rule: may write the !sel half only while buffer_empty_o=1.

Swap (one cycle):
- sel toggles, addr=0, pending cleared.
- buffer_empty_o rises the next cycle.
- If a new filled_i edge arrives in the swap cycle, the edge wins: pending stays 1.

States:
- IDLE: wait for pending=1, then SWAP. The first playback therefore uses half 1.
- SWAP: perform the swap, then WAIT_TICK.
- WAIT_TICK: on sample_tick_i, enter FETCH with byte counter=0.
- FETCH: present addr, wait RAM_RD_LATENCY cycles, capture the byte into the shift register, increment addr (modulo 2^BUFFER_ADDR_BITS).
  - Byte order: L[7:0], L[15:8], R[7:0], R[15:8].
  - After byte 3, go to EMIT. Otherwise repeat FETCH.
- EMIT: load the outputs and pulse sample_valid_o for 1 cycle.
  - If addr wrapped to 0 and pending=1: SWAP.
  - If addr wrapped and pending=0: UNDERRUN.
  - Otherwise: WAIT_TICK.
- UNDERRUN: underrun_o=1 and addr held at 0. When pending=1, go to SWAP.

Timing:
- Fetch latency is 4*(1+RAM_RD_LATENCY) cycles.
- Tick to sample_valid_o is 4*(1+RAM_RD_LATENCY)+1 cycles (9 at the default).

Tick handling:
- A tick outside WAIT_TICK (FETCH/EMIT/SWAP) is dropped and sets tick_missed_o.
- A tick during UNDERRUN or IDLE is dropped silently (apart from the optional feature below).

Optional Feature:
Macro: UNDERRUN_MUTE_EN
- Defined: in UNDERRUN, each sample_tick_i produces a 1-cycle sample_valid_o with left=right=0, on the cycle after the tick. The codec keeps a steady stream.
- Undefined: no sample_valid_o during UNDERRUN; the output stalls and holds the last sample values.

Decomposition:
- Shared package buffer_pkg:
  - state enum (IDLE, SWAP, WAIT_TICK, FETCH, EMIT, UNDERRUN)
  - SAMPLE_BYTES=4, SAMPLE_BITS=16
  - BUFFER_ADDR_BITS default, shared with the writer and the RAM address split
- Sub-module sample_assembler: byte shift-in register with capture enable and byte index, producing the left/right words. Keeps the FSM free of datapath.

Test Plan:
1. Reset, then filled_i rises at cycle 10 -> buffer_empty_o falls; swap to sel=1 with addr=0; buffer_empty_o rises 1 cycle after the swap.
2. Half 1 bytes 0..3 = 34 12 78 56, one tick -> 9 cycles later sample_valid_o with left=16'h1234, right=16'h5678; addr=4.
3. BUFFER_ADDR_BITS=4, 4 ticks with pending=1 -> after the 4th EMIT, addr wraps to 0 and sel toggles to 0; no underrun.
4. Same as 3 but without a second fill -> underrun_o=1 after the 4th EMIT; a filled_i edge 50 cycles later -> swap, underrun_o=0, playback resumes from addr 0.
5. Two ticks 3 cycles apart -> only one sample_valid_o; tick_missed_o=1 and stays 1 until reset.
6. rst_n low during FETCH byte 2 -> all outputs at reset values immediately; no sample_valid_o after release until a new fill and a new tick.
